// File: rtl/lab_mux_arbiter.sv
// Round-robin owner of the board's 2-to-1 mux: synchronizes and debounces two
// switch requests, then grants the mux to one requester at a time with a minimum hold.
module lab_mux_arbiter #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_x,
  input  logic req_y,
  input  logic x,
  input  logic y,
  output logic s,
  output logic gnt_x,
  output logic gnt_y,
  output logic busy,
  output logic m
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_X = 2'd1,
    GRANT_Y = 2'd2
  } state_t;

  // Bit 0 carries requester X, bit 1 carries requester Y.
  logic [1:0]     req_raw;
  logic [1:0]     sync_p0;
  logic [1:0]     sync_p1;
  logic [1:0]     deb_p2;
  logic [DBW-1:0] cnt [2];

  state_t         state;
  logic           last;     // 0 = X served last, 1 = Y served last
  logic [HW-1:0]  hold;
  logic           expired;
  logic           deb_x;
  logic           deb_y;

  assign req_raw = {req_y, req_x};

  // Stage p0/p1: two-flop synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= req_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debouncer; a glitch back to the accepted level restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_p2 <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] != deb_p2[i]) begin
          if (cnt[i] == DB_LAST) begin
            deb_p2[i] <= sync_p1[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign deb_x   = deb_p2[0];
  assign deb_y   = deb_p2[1];
  assign expired = (hold == HOLD_LAST);

  // Arbiter FSM with registered select and grant outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      hold  <= '0;
      s     <= 1'b0;
      gnt_x <= 1'b0;
      gnt_y <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (deb_x && (!deb_y || last)) begin
            state <= GRANT_X;
            hold  <= '0;
            s     <= 1'b0;
            gnt_x <= 1'b1;
            gnt_y <= 1'b0;
            last  <= 1'b0;
          end else if (deb_y) begin
            state <= GRANT_Y;
            hold  <= '0;
            s     <= 1'b1;
            gnt_x <= 1'b0;
            gnt_y <= 1'b1;
            last  <= 1'b1;
          end
        end
        GRANT_X: begin
          if (!expired) begin
            hold <= hold + 1'b1;
          end else if (deb_y) begin
            state <= GRANT_Y;
            hold  <= '0;
            s     <= 1'b1;
            gnt_x <= 1'b0;
            gnt_y <= 1'b1;
            last  <= 1'b1;
          end else if (!deb_x) begin
            state <= IDLE;
            hold  <= '0;
            gnt_x <= 1'b0;
            gnt_y <= 1'b0;
          end
        end
        GRANT_Y: begin
          if (!expired) begin
            hold <= hold + 1'b1;
          end else if (deb_x) begin
            state <= GRANT_X;
            hold  <= '0;
            s     <= 1'b0;
            gnt_x <= 1'b1;
            gnt_y <= 1'b0;
            last  <= 1'b0;
          end else if (!deb_y) begin
            state <= IDLE;
            hold  <= '0;
            gnt_x <= 1'b0;
            gnt_y <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          hold  <= '0;
          gnt_x <= 1'b0;
          gnt_y <= 1'b0;
        end
      endcase
    end
  end

  // Gated mux output: driven from the registered grants, 0 while idle
  assign busy = gnt_x | gnt_y;
  assign m    = (gnt_x & x) | (gnt_y & y);

endmodule

// File: tb/tb_lab_mux_arbiter.sv
// Bench for lab_mux_arbiter: directed scenarios plus randomized request traffic,
// all checked each cycle against a cycle-level behavioural model.
module tb_lab_mux_arbiter;

  localparam int DB = 4;
  localparam int HC = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic req_x = 1'b0;
  logic req_y = 1'b0;
  logic x     = 1'b0;
  logic y     = 1'b0;
  logic s, gnt_x, gnt_y, busy, m;

  int n_cmp = 0;
  int n_err = 0;

  lab_mux_arbiter #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req_x(req_x),
    .req_y(req_y),
    .x    (x),
    .y    (y),
    .s    (s),
    .gnt_x(gnt_x),
    .gnt_y(gnt_y),
    .busy (busy),
    .m    (m)
  );

  always #5 clk = ~clk;

  // Model state: index 0 is requester X, index 1 is requester Y.
  // owner: 0 = nobody, 1 = X, 2 = Y. age counts cycles since the grant began.
  bit mdl_s1 [2];
  bit mdl_s2 [2];
  bit mdl_deb [2];
  int mdl_run [2];
  int mdl_owner;
  int mdl_age;
  int mdl_last;
  bit mdl_sel;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mdl_s1[i]  = 1'b0;
      mdl_s2[i]  = 1'b0;
      mdl_deb[i] = 1'b0;
      mdl_run[i] = 0;
    end
    mdl_owner = 0;
    mdl_age   = 0;
    mdl_last  = 2;
    mdl_sel   = 1'b0;
  endtask

  // One rising edge of the specified behaviour, computed from pre-edge values.
  task automatic model_edge();
    bit r [2];
    int nxt;
    bit held_long;
    r[0] = req_x;
    r[1] = req_y;
    held_long = (mdl_age >= HC - 1);
    if (mdl_owner == 0) begin
      if (mdl_deb[0] && mdl_deb[1]) nxt = (mdl_last == 1) ? 2 : 1;
      else if (mdl_deb[0])          nxt = 1;
      else if (mdl_deb[1])          nxt = 2;
      else                          nxt = 0;
    end else if (!held_long) begin
      nxt = mdl_owner;
    end else if (mdl_deb[2 - mdl_owner]) begin
      nxt = 3 - mdl_owner;
    end else if (!mdl_deb[mdl_owner - 1]) begin
      nxt = 0;
    end else begin
      nxt = mdl_owner;
    end
    if (nxt != 0 && nxt != mdl_owner) begin
      mdl_age  = 0;
      mdl_last = nxt;
      mdl_sel  = (nxt == 2);
    end else if (nxt != 0) begin
      mdl_age = (mdl_age + 1 > HC - 1) ? HC - 1 : mdl_age + 1;
    end
    mdl_owner = nxt;
    // A level is accepted on its DB-th consecutive differing sample.
    for (int i = 0; i < 2; i++) begin
      if (mdl_s2[i] != mdl_deb[i]) begin
        mdl_run[i]++;
        if (mdl_run[i] == DB) begin
          mdl_deb[i] = mdl_s2[i];
          mdl_run[i] = 0;
        end
      end else begin
        mdl_run[i] = 0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      mdl_s2[i] = mdl_s1[i];
      mdl_s1[i] = r[i];
    end
  endtask

  task automatic cmp_all();
    chk("gnt_x", gnt_x, mdl_owner == 1);
    chk("gnt_y", gnt_y, mdl_owner == 2);
    chk("s", s, mdl_sel);
    chk("busy", busy, mdl_owner != 0);
    chk("m", m, ((mdl_owner == 1) & x) | ((mdl_owner == 2) & y));
    chk("mutex", gnt_x & gnt_y, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_all();
  endtask

  // Asserts reset mid-cycle, checks the asynchronous drop, releases away from an edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp_all();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    do_reset();
    chk("rst_s", s, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m", m, 1'b0);

    // Single request: grant on edge 7, release 7 edges after the drop
    x = 1'b1;
    req_x = 1'b1;
    repeat (6) step();
    chk("t1_early", gnt_x, 1'b0);
    step();
    chk("t1_gnt_x", gnt_x, 1'b1);
    chk("t1_s", s, 1'b0);
    chk("t1_m", m, 1'b1);
    repeat (5) step();
    req_x = 1'b0;
    repeat (6) step();
    chk("t1_still", gnt_x, 1'b1);
    step();
    chk("t1_off", gnt_x, 1'b0);
    chk("t1_m_off", m, 1'b0);

    // Short pulse on req_y must be rejected
    repeat (4) step();
    req_y = 1'b1;
    repeat (3) step();
    req_y = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("t2_busy", busy, 1'b0);
      chk("t2_gnt_y", gnt_y, 1'b0);
    end

    // Simultaneous requests: X first, then alternation every HC cycles
    do_reset();
    req_x = 1'b1;
    req_y = 1'b1;
    repeat (7) step();
    chk("t3_x7", gnt_x, 1'b1);
    repeat (2) step();
    chk("t3_x9", gnt_x, 1'b1);
    step();
    chk("t3_y10", gnt_y, 1'b1);
    chk("t3_s10", s, 1'b1);
    repeat (3) step();
    chk("t3_x13", gnt_x, 1'b1);
    chk("t3_s13", s, 1'b0);
    repeat (3) step();
    chk("t3_y16", gnt_y, 1'b1);
    req_x = 1'b0;
    req_y = 1'b0;
    repeat (12) step();

    // Minimum hold: request dropped one cycle after the grant
    do_reset();
    req_x = 1'b1;
    repeat (7) step();
    step();
    req_x = 1'b0;
    repeat (6) step();
    chk("t4_held", gnt_x, 1'b1);
    step();
    chk("t4_off", gnt_x, 1'b0);

    // Mux data path while Y is granted, then reset mid-grant
    do_reset();
    req_y = 1'b1;
    x = 1'b1;
    y = 1'b0;
    repeat (7) step();
    chk("t6_gnt_y", gnt_y, 1'b1);
    chk("t6_m_y0", m, 1'b0);
    y = 1'b1; #1;
    chk("t6_m_y1", m, 1'b1);
    x = 1'b0; #1;
    chk("t6_m_x0", m, 1'b1);
    y = 1'b0; #1;
    chk("t6_m_y0b", m, 1'b0);
    x = 1'b1; #1;
    chk("t6_m_x1", m, 1'b0);
    repeat (2) step();
    do_reset();
    chk("t5_s", s, 1'b0);
    chk("t5_gnt_y", gnt_y, 1'b0);
    chk("t5_m", m, 1'b0);
    repeat (6) step();
    chk("t5_early", gnt_y, 1'b0);
    step();
    chk("t5_regrant", gnt_y, 1'b1);
    req_y = 1'b0;
    repeat (12) step();

    // Randomized request traffic with occasional resets
    for (int seg = 0; seg < 400; seg++) begin
      int len;
      if ($urandom_range(0, 99) < 40) req_x = ~req_x;
      if ($urandom_range(0, 99) < 40) req_y = ~req_y;
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        x = 1'($urandom_range(0, 1));
        y = 1'($urandom_range(0, 1));
        step();
      end
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lab_mux_arbiter.md
# lab_mux_arbiter

Round-robin arbiter that shares the board's 2-to-1 multiplexer between two switch-driven requesters. Raw switch requests are synchronized and debounced. A three-state FSM then grants the mux to one requester at a time, with a guaranteed minimum hold time. The block drives the mux select line and grant LEDs, and presents the gated mux output `m`. It sits between the board switches and the existing gate-level mux datapath, replacing the hand-operated select switch.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept a request change. Must be ≥ 2.
- `HOLD_CYCLES`, default 8: minimum number of cycles a grant is held once issued. Must be ≥ 1.

- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_x`  in  1  raw switch request for data input `x`. Asynchronous to `clk`.
- `req_y`  in  1  raw switch request for data input `y`. Asynchronous to `clk`.
- `x`  in  1  data bit of requester X.
- `y`  in  1  data bit of requester Y.
- `s`  out  1  mux select, registered. 0 selects `x`, 1 selects `y`.
- `gnt_x`  out  1  grant LED for X, registered.
- `gnt_y`  out  1  grant LED for Y, registered.
- `busy`  out  1  `gnt_x | gnt_y`.
- `m`  out  1  `(gnt_x & x) | (gnt_y & y)`. Combinational from the registered grants; equal to `s ? y : x` while busy, 0 when idle.

## Operation
- **Synchronizer:** two flops per request, reset to 0.
- **Debouncer:** one counter per request, width clog2(`DEBOUNCE_CYCLES`).
  - If sync ≠ deb and cnt == `DEBOUNCE_CYCLES`−1: deb ← sync, cnt ← 0.
  - Else if sync ≠ deb: cnt ← cnt+1.
  - Else: cnt ← 0. Any glitch back to the old value restarts the count.
- **FSM states:** IDLE, GRANT_X, GRANT_Y. Reset state is IDLE.
- **last register:** remembers the last served requester. It resets to Y, so X wins the first tie.
- **IDLE:**
  - Only deb_x → GRANT_X.
  - Only deb_y → GRANT_Y.
  - Both → grant the requester not equal to `last`.
  - Neither → stay in IDLE. `s` holds its previous value.
- **Hold counter:** cleared to 0 on every grant entry, including X↔Y switches. Increments each cycle in a GRANT state and saturates at `HOLD_CYCLES`−1. "Expired" means hold == `HOLD_CYCLES`−1.
- **GRANT_X before expiry:** stay, regardless of the requests.
- **GRANT_X after expiry:**
  - deb_y → GRANT_Y directly, with no idle cycle.
  - Else if !deb_x → IDLE.
  - Else stay.
- **GRANT_Y:** symmetric to GRANT_X.
- **On entering GRANT_X:** `s`←0, `gnt_x`←1, `gnt_y`←0, `last`←X. GRANT_Y is symmetric.
- **On entering IDLE:** `gnt_x`←0, `gnt_y`←0. `s` and `last` are unchanged.
- **Invariant:** `gnt_x & gnt_y` is never 1.

## Timing
- **Reset values:** `s`=0, `gnt_x`=0, `gnt_y`=0, `busy`=0, `m`=0. All synchronizer, debounce, hold and FSM registers are cleared.
- **Reset mid-grant:** all outputs drop asynchronously. After release, a request that is still asserted must be re-debounced before any grant. Total latency is `DEBOUNCE_CYCLES`+3 edges.
- **Request-to-grant latency from IDLE:** `DEBOUNCE_CYCLES`+3 rising edges. Edge 1 is the first edge that samples the new level. Breakdown: 2 synchronizer edges + `DEBOUNCE_CYCLES` debounce edges + 1 FSM edge.
- **Release latency:** the grant drops exactly one edge after the later of these two events:
  - hold expiry;
  - the debounced request deasserting. Debounced deassertion occurs `DEBOUNCE_CYCLES`+2 edges after the raw deassertion.
- **Switch-over:** `s`, `gnt_x` and `gnt_y` all change on the same edge. `m` follows combinationally in the same cycle.
- **Simultaneous debounced rise** of both requests in IDLE: the requester not equal to `last` is granted. The other is granted at the edge after the first grant's hold expires, provided it is still requesting.
- **Continuous contention:** the two requesters alternate. Each grant lasts exactly `HOLD_CYCLES` cycles.

## Test plan
Use `DEBOUNCE_CYCLES`=4 and `HOLD_CYCLES`=3 throughout.
1. **Reset and single request:** after reset, assert `req_x` with `x`=1 → `gnt_x`=1, `s`=0, `m`=1 at edge 7. Drop `req_x` → `gnt_x`=0 and `m`=0 seven edges later.
2. **Debounce rejection:** pulse `req_y` high for 3 cycles, then low → `gnt_y` stays 0 and `busy` stays 0 throughout.
3. **First-tie priority:** after reset, assert `req_x` and `req_y` on the same cycle → `gnt_x` at edge 7, then `gnt_y`=1 and `s`=1 at edge 10. The pattern X for 3 cycles, Y for 3 cycles repeats while both are held.
4. **Minimum hold:** grant X, then drop `req_x` one cycle after the grant → `gnt_x` remains 1 for at least 3 cycles. It falls at the edge after debounced `req_x` goes low.
5. **Mid-grant reset:** during GRANT_Y, pulse `rst_n` low asynchronously → `s`, `gnt_y` and `m` are 0 immediately. With `req_y` still high, `gnt_y` returns 7 edges after `rst_n` rises.
6. **Mux data path:** hold GRANT_Y and toggle `y` 0→1→0 and `x` 1→0 → `m` tracks `y` only and never `x`. A checker asserts `!(gnt_x & gnt_y)` on every cycle.
